param_bounce_counter: RTL and testbench

- Parametrised up/down counter with programmable lower and upper limits.
- Run-time modes: up-wrap, down-wrap, bounce (triangle) and hold; plus enable, synchronous load, direction output and a turn/wrap event pulse.
- Successor to the fixed 4-bit bounce counter; used as a pattern, sweep and timebase source in the exercise designs.

---
 rtl/counter_pkg.sv | 14 +
 rtl/param_bounce_counter.sv | 128 ++++++++++++
 tb/tb_param_bounce_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encoding and direction constants for the bounce counter
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/param_bounce_counter.sv
// rtl/param_bounce_counter.sv - up/down/bounce counter with programmable inclusive limits
module param_bounce_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             evt,
  output logic             at_lo,
  output logic             at_hi,
  output logic             cfg_err
);

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_evt;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_dir_nxt;
  logic             w_evt_nxt;
  logic             w_cfg_err;
  logic             w_out_of_range;
  mode_e            w_mode;

  assign w_mode         = mode_e'(mode);
  assign w_cfg_err      = (lo > hi);
  assign w_out_of_range = (r_count < lo) || (r_count > hi);

  assign count   = r_count;
  assign dir     = r_dir;
  assign evt     = r_evt;
  assign at_lo   = (r_count == lo);
  assign at_hi   = (r_count == hi);
  assign cfg_err = w_cfg_err;

  // Next-state: load beats a bad config, which beats enable; anything else holds.
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_evt_nxt   = 1'b0;
    if (load) begin
      w_count_nxt = load_val;
    end else if (w_cfg_err) begin
      // limits are inconsistent: freeze until software fixes them
    end else if (en && (w_mode != MODE_HOLD)) begin
      if (w_out_of_range) begin
        // snap back to the endpoint the active mode starts from
        if (w_mode == MODE_DOWN) begin
          w_count_nxt = hi;
          w_dir_nxt   = DIR_DOWN;
        end else begin
          w_count_nxt = lo;
          w_dir_nxt   = DIR_UP;
        end
        w_evt_nxt = 1'b1;
      end else if (lo == hi) begin
        // single-point range: nothing to step to, so no wrap/turn event
      end else begin
        case (w_mode)
          MODE_UP: begin
            w_dir_nxt = DIR_UP;
            if (r_count == hi) begin
              w_count_nxt = lo;
              w_evt_nxt   = 1'b1;
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end
          MODE_DOWN: begin
            w_dir_nxt = DIR_DOWN;
            if (r_count == lo) begin
              w_count_nxt = hi;
              w_evt_nxt   = 1'b1;
            end else begin
              w_count_nxt = r_count - 1'b1;
            end
          end
          MODE_BOUNCE: begin
            // endpoints are visited once: turning steps straight past them
            if (r_dir == DIR_UP) begin
              if (r_count == hi) begin
                w_count_nxt = hi - 1'b1;
                w_dir_nxt   = DIR_DOWN;
                w_evt_nxt   = 1'b1;
              end else begin
                w_count_nxt = r_count + 1'b1;
              end
            end else begin
              if (r_count == lo) begin
                w_count_nxt = lo + 1'b1;
                w_dir_nxt   = DIR_UP;
                w_evt_nxt   = 1'b1;
              end else begin
                w_count_nxt = r_count - 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= WIDTH'(RST_VAL);
      r_dir   <= DIR_UP;
      r_evt   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_evt   <= w_evt_nxt;
    end
  end

endmodule

// File: tb/tb_param_bounce_counter.sv
// tb/tb_param_bounce_counter.sv - directed scoreboard bench for param_bounce_counter
module tb_param_bounce_counter;
  import counter_pkg::*;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             evt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             evt;
  logic             at_lo;
  logic             at_hi;
  logic             cfg_err;

  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  param_bounce_counter #(.WIDTH(WIDTH), .RST_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .load(load), .load_val(load_val), .count(count), .dir(dir), .evt(evt),
    .at_lo(at_lo), .at_hi(at_hi), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic step(input string tag, input logic [WIDTH-1:0] c, input logic d, input logic e);
    exp_t x;
    exp_t y;
    x.count = c;
    x.dir   = d;
    x.evt   = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk({tag, ".count"}, 32'(count), 32'(y.count));
    chk({tag, ".dir"},   32'(dir),   32'(y.dir));
    chk({tag, ".evt"},   32'(evt),   32'(y.evt));
  endtask

  initial begin
    logic [WIDTH-1:0] ec;
    logic             ed;
    logic             ee;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = MODE_BOUNCE;
    lo       = 4'd0;
    hi       = 4'd15;
    load     = 1'b0;
    load_val = 4'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.dir", 32'(dir), 0);
    chk("rst.evt", 32'(evt), 0);
    chk("rst.at_lo", 32'(at_lo), 1);
    chk("rst.cfg_err", 32'(cfg_err), 0);

    // full-range bounce for 32 cycles
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i <= 15) begin
        ec = 4'(i);      ed = 1'b0;
      end else if (i <= 30) begin
        ec = 4'(30 - i); ed = 1'b1;
      end else begin
        ec = 4'(i - 30); ed = 1'b0;
      end
      ee = (i == 16) || (i == 31);
      step($sformatf("bounce%0d", i), ec, ed, ee);
    end

    // load wins over enable mid-bounce; dir kept
    load = 1'b1; load_val = 4'd9;
    step("load9", 4'd9, 1'b0, 1'b0);

    // MODE_UP wrap within 3..6
    mode = MODE_UP; lo = 4'd3; hi = 4'd6; load_val = 4'd3;
    step("load3", 4'd3, 1'b0, 1'b0);
    load = 1'b0;
    step("up4", 4'd4, 1'b0, 1'b0);
    step("up5", 4'd5, 1'b0, 1'b0);
    step("up6", 4'd6, 1'b0, 1'b0);
    chk("up6.at_hi", 32'(at_hi), 1);
    step("up3", 4'd3, 1'b0, 1'b1);
    chk("up3.at_lo", 32'(at_lo), 1);
    step("up4b", 4'd4, 1'b0, 1'b0);

    // out-of-range recovery in MODE_UP
    load = 1'b1; load_val = 4'd12;
    step("load12", 4'd12, 1'b0, 1'b0);
    load = 1'b0;
    step("uprec", 4'd3, 1'b0, 1'b1);

    // MODE_DOWN recovery from 10 then count down and wrap
    load = 1'b1; load_val = 4'd10; mode = MODE_DOWN;
    step("load10", 4'd10, 1'b0, 1'b0);
    load = 1'b0;
    step("dnrec", 4'd6, 1'b1, 1'b1);
    step("dn5", 4'd5, 1'b1, 1'b0);
    step("dn4", 4'd4, 1'b1, 1'b0);
    step("dn3", 4'd3, 1'b1, 1'b0);
    step("dn6", 4'd6, 1'b1, 1'b1);

    // enable gating in MODE_UP, then MODE_HOLD
    mode = MODE_UP;
    step("en1a", 4'd3, 1'b0, 1'b1);
    en = 1'b0;
    step("en0a", 4'd3, 1'b0, 1'b0);
    step("en0b", 4'd3, 1'b0, 1'b0);
    en = 1'b1;
    step("en1b", 4'd4, 1'b0, 1'b0);
    mode = MODE_HOLD;
    step("hold1", 4'd4, 1'b0, 1'b0);
    step("hold2", 4'd4, 1'b0, 1'b0);

    // inverted limits freeze the counter
    mode = MODE_UP; lo = 4'd8; hi = 4'd5;
    #1;
    chk("cfg_err", 32'(cfg_err), 1);
    for (int i = 0; i < 5; i++) step($sformatf("cfg%0d", i), 4'd4, 1'b0, 1'b0);

    // degenerate single-point range
    lo = 4'd7; hi = 4'd7; load = 1'b1; load_val = 4'd7;
    step("load7", 4'd7, 1'b0, 1'b0);
    load = 1'b0;
    step("deg1", 4'd7, 1'b0, 1'b0);
    step("deg2", 4'd7, 1'b0, 1'b0);
    chk("deg.at_lo", 32'(at_lo), 1);
    chk("deg.at_hi", 32'(at_hi), 1);

    // async reset mid-sweep, right after a turn event
    lo = 4'd0; hi = 4'd15; mode = MODE_BOUNCE;
    step("sw8", 4'd8, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd15;
    step("load15", 4'd15, 1'b0, 1'b0);
    load = 1'b0;
    step("turn", 4'd14, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.dir", 32'(dir), 0);
    chk("arst.evt", 32'(evt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 4'd1, 1'b0, 1'b0);

    chk("sb.empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
